huffman_param: RTL and testbench

- Parametrised successor of the fixed 6-symbol Huffman encoder.
- Counts the symbols 1..NSYM in a gray-data frame and reports the counts.
- Builds Huffman codes with one merge per cycle.
- Outputs right-aligned codes plus length masks on flat buses; sits between the image-stream source and the code packer.

---
 rtl/huffman_param.sv | 173 +++++++++++++++++
 tb/tb_huffman_param.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_param.sv
// huffman_param: per-frame histogram of symbols 1..NSYM, then Huffman codes built one merge per cycle (HUFF_CNT_SAT_EN: saturating counts).
// Latency: CNT_valid 1 cycle after gray_valid falls, code_valid NSYM cycles later; no backpressure, samples outside IDLE/COUNT are dropped.
module huffman_param #(
  parameter int NSYM = 6,
  parameter int DW   = 8,
  parameter int CW   = 8,
  parameter int LW   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               gray_valid,
  input  logic [DW-1:0]      gray_data,
  output logic               CNT_valid,
  output logic [NSYM*CW-1:0] CNT,
  output logic               code_valid,
  output logic [NSYM*LW-1:0] HC,
  output logic [NSYM*LW-1:0] M
);
  localparam int IW = $clog2(NSYM);
  localparam int WW = CW + $clog2(NSYM);

  if (LW < NSYM - 1) begin : g_lw_chk
    $error("huffman_param: LW must be >= NSYM-1");
  end
  if (NSYM < 2 || NSYM > 16) begin : g_nsym_chk
    $error("huffman_param: NSYM must be in 2..16");
  end

  typedef enum logic [2:0] {IDLE, COUNT, REPORT, MERGE, DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]   cnt    [NSYM];
  logic [LW-1:0]   hc     [NSYM];
  logic [LW-1:0]   mk     [NSYM];
  logic [IW-1:0]   len    [NSYM];
  logic [IW-1:0]   grp    [NSYM];
  logic [WW-1:0]   weight [NSYM];
  logic [NSYM-1:0] active;
  logic [IW-1:0]   mcnt;

  logic          in_range;
  logic [IW-1:0] sym_idx;
  logic          have1, have2;
  logic [IW-1:0] min1, min2, new_id, old_id;
  logic [WW-1:0] w_min1, w_min2;

  always_comb begin
    in_range = (gray_data != '0) && (gray_data <= DW'(NSYM));
    sym_idx  = IW'(gray_data - DW'(1));
  end

  // Ascending scan with <= so that, on equal weight, the larger id is chosen.
  always_comb begin
    have1  = 1'b0;
    min1   = '0;
    w_min1 = '0;
    for (int g = 0; g < NSYM; g++) begin
      if (active[g] && (!have1 || weight[g] <= w_min1)) begin
        have1  = 1'b1;
        min1   = IW'(g);
        w_min1 = weight[g];
      end
    end
    have2  = 1'b0;
    min2   = '0;
    w_min2 = '0;
    for (int g = 0; g < NSYM; g++) begin
      if (active[g] && (IW'(g) != min1) && (!have2 || weight[g] <= w_min2)) begin
        have2  = 1'b1;
        min2   = IW'(g);
        w_min2 = weight[g];
      end
    end
    new_id = (min1 < min2) ? min1 : min2;
    old_id = (min1 < min2) ? min2 : min1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    CNT_valid  = 1'b0;
    code_valid = 1'b0;
    case (state)
      IDLE:   if (gray_valid) state_nxt = COUNT;
      COUNT:  if (!gray_valid) state_nxt = REPORT;
      REPORT: begin
        CNT_valid = 1'b1;
        state_nxt = MERGE;
      end
      MERGE:  if (mcnt == IW'(NSYM - 2)) state_nxt = DONE;
      DONE: begin
        code_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NSYM; s++) begin
        cnt[s]    <= '0;
        hc[s]     <= '0;
        mk[s]     <= '0;
        len[s]    <= '0;
        grp[s]    <= '0;
        weight[s] <= '0;
      end
      active <= '0;
      mcnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gray_valid) begin
            for (int s = 0; s < NSYM; s++) begin
              cnt[s] <= '0;
              hc[s]  <= '0;
              mk[s]  <= '0;
              len[s] <= '0;
            end
            if (in_range) cnt[sym_idx] <= CW'(1);
          end
        end
        COUNT: begin
          if (gray_valid && in_range) begin
`ifdef HUFF_CNT_SAT_EN
            if (cnt[sym_idx] != '1) cnt[sym_idx] <= cnt[sym_idx] + CW'(1);
`else
            cnt[sym_idx] <= cnt[sym_idx] + CW'(1);
`endif
          end
        end
        REPORT: begin
          for (int s = 0; s < NSYM; s++) begin
            weight[s] <= WW'(cnt[s]);
            grp[s]    <= IW'(s);
            len[s]    <= '0;
            hc[s]     <= '0;
            mk[s]     <= '0;
          end
          active <= '1;
          mcnt   <= '0;
        end
        MERGE: begin
          mcnt <= mcnt + IW'(1);
          // The new bit lands above the existing ones, so it becomes the code MSB.
          for (int s = 0; s < NSYM; s++) begin
            if (grp[s] == min1 || grp[s] == min2) begin
              if (grp[s] == min1) hc[s] <= hc[s] | (LW'(1) << len[s]);
              mk[s]  <= (mk[s] << 1) | LW'(1);
              len[s] <= len[s] + IW'(1);
              grp[s] <= new_id;
            end
          end
          weight[new_id] <= w_min1 + w_min2;
          active[old_id] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < NSYM; k++) begin : g_out
    assign CNT[k*CW +: CW] = cnt[k];
    assign HC[k*LW +: LW]  = hc[k];
    assign M[k*LW +: LW]   = mk[k];
  end

endmodule

// File: tb/tb_huffman_param.sv
// Directed bench for huffman_param: a 6-symbol instance plus a 4-symbol/4-bit-code instance.
// Expected codes, masks and counts are hand-derived constants.
module tb_huffman_param;
  logic        clk = 1'b0;
  logic        reset;
  logic        gv6, gv4;
  logic [7:0]  gd6, gd4;
  logic        cv6, cv4, codev6, codev4;
  logic [47:0] cnt6, hc6, m6;
  logic [31:0] cnt4;
  logic [15:0] hc4, m4;

  int n_checks = 0;
  int n_fail   = 0;
  int fq[$];

  localparam logic [47:0] T1_CNT = {8'd30, 8'd30, 8'd5, 8'd5, 8'd20, 8'd10};
  localparam logic [47:0] T1_HC  = {8'h01, 8'h00, 8'h0B, 8'h0A, 8'h03, 8'h04};
  localparam logic [47:0] T1_M   = {8'h03, 8'h03, 8'h0F, 8'h0F, 8'h03, 8'h07};

  always #5 clk = ~clk;

  huffman_param dut6 (
    .clk(clk), .reset(reset), .gray_valid(gv6), .gray_data(gd6),
    .CNT_valid(cv6), .CNT(cnt6), .code_valid(codev6), .HC(hc6), .M(m6)
  );

  huffman_param #(.NSYM(4), .DW(8), .CW(8), .LW(4)) dut4 (
    .clk(clk), .reset(reset), .gray_valid(gv4), .gray_data(gd4),
    .CNT_valid(cv4), .CNT(cnt4), .code_valid(codev4), .HC(hc4), .M(m4)
  );

  task automatic fill_test1();
    int c[6] = '{10, 20, 5, 5, 30, 30};
    fq.delete();
    for (int s = 0; s < 6; s++)
      for (int j = 0; j < c[s]; j++) fq.push_back(s + 1);
  endtask

  // Drives the queued samples; returns on the first cycle with gray_valid low.
  task automatic play6();
    foreach (fq[i]) begin
      @(negedge clk);
      gv6 = 1'b1;
      gd6 = 8'(fq[i]);
    end
    @(negedge clk);
    gv6 = 1'b0;
    gd6 = 8'd0;
  endtask

  // Watches code_valid for 20 cycles: first-pulse offset (-1 if none) and pulse count.
  task automatic wait_code6(output int cyc, output int pulses);
    cyc = -1;
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (codev6) begin
        if (cyc < 0) cyc = i;
        pulses++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    gv6 = 1'b0; gd6 = '0; gv4 = 1'b0; gd4 = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cv6, codev6, cnt6, hc6, m6} !== '0) begin
      n_fail++;
      $display("FAIL reset_in: got cv=%b codev=%b cnt=%h hc=%h m=%h, expected all 0", cv6, codev6, cnt6, hc6, m6);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({cv6, codev6, cnt6, hc6, m6, cv4, codev4, cnt4, hc4, m4} !== '0) begin
      n_fail++;
      $display("FAIL reset_out: outputs not zero after reset release (cnt6=%h hc4=%h)", cnt6, hc4);
    end
  endtask

  task automatic test_main();
    int cyc, pulses;
    fill_test1();
    play6();
    @(negedge clk);
    n_checks++;
    if (cv6 !== 1'b1) begin
      n_fail++;
      $display("FAIL main_cnt_valid: got %b, expected 1 one cycle after gray_valid fell", cv6);
    end
    n_checks++;
    if (cnt6 !== T1_CNT) begin
      n_fail++;
      $display("FAIL main_cnt: got %h, expected %h", cnt6, T1_CNT);
    end
    wait_code6(cyc, pulses);
    n_checks++;
    if (cyc !== 6) begin
      n_fail++;
      $display("FAIL main_code_latency: got %0d, expected 6", cyc);
    end
    n_checks++;
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL main_code_pulses: got %0d, expected 1", pulses);
    end
    n_checks++;
    if (hc6 !== T1_HC) begin
      n_fail++;
      $display("FAIL main_hc: got %h, expected %h", hc6, T1_HC);
    end
    n_checks++;
    if (m6 !== T1_M) begin
      n_fail++;
      $display("FAIL main_m: got %h, expected %h", m6, T1_M);
    end
  endtask

  task automatic test_small();
    int cyc = -1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      gv4 = 1'b1;
      gd4 = 8'(i + 1);
    end
    @(negedge clk);
    gv4 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cv4 !== 1'b1 || cnt4 !== 32'h01010101) begin
      n_fail++;
      $display("FAIL small_cnt: got cv=%b cnt=%h, expected cv=1 cnt=01010101", cv4, cnt4);
    end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (codev4 && cyc < 0) cyc = i;
    end
    n_checks++;
    if (cyc !== 4) begin
      n_fail++;
      $display("FAIL small_code_latency: got %0d, expected 4", cyc);
    end
    n_checks++;
    if (hc4 !== 16'h3210 || m4 !== 16'h3333) begin
      n_fail++;
      $display("FAIL small_codes: got hc=%h m=%h, expected hc=3210 m=3333", hc4, m4);
    end
  endtask

  task automatic test_ignore();
    int cyc, pulses;
    fq = '{2, 0, 7, 9, 3, 3};
    play6();
    @(negedge clk);
    n_checks++;
    if (cv6 !== 1'b1 || cnt6 !== 48'h000000020100) begin
      n_fail++;
      $display("FAIL ignore_cnt: got cv=%b cnt=%h, expected cv=1 cnt=000000020100", cv6, cnt6);
    end
    wait_code6(cyc, pulses);
    n_checks++;
    if (pulses !== 1 || cyc !== 6) begin
      n_fail++;
      $display("FAIL ignore_code_valid: got %0d pulses at %0d, expected 1 at 6", pulses, cyc);
    end
    n_checks++;
    if (hc6 !== 48'h1F1E0E000206 || m6 !== 48'h1F1F0F010307) begin
      n_fail++;
      $display("FAIL ignore_codes: got hc=%h m=%h, expected hc=1F1E0E000206 m=1F1F0F010307", hc6, m6);
    end
  endtask

  task automatic test_count_width();
    int cyc, pulses;
    logic [7:0] exp1;
`ifdef HUFF_CNT_SAT_EN
    exp1 = 8'd255;
`else
    exp1 = 8'd44;
`endif
    fq.delete();
    for (int i = 0; i < 300; i++) fq.push_back(1);
    play6();
    @(negedge clk);
    n_checks++;
    if (cnt6 !== {40'h0, exp1}) begin
      n_fail++;
      $display("FAIL count_width: got %h, expected %h", cnt6, {40'h0, exp1});
    end
    wait_code6(cyc, pulses);
    n_checks++;
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL count_width_code: got %0d pulses, expected 1", pulses);
    end
  endtask

  task automatic test_reset_mid_merge();
    int cyc, pulses;
    fill_test1();
    play6();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({cv6, codev6, cnt6, hc6, m6} !== '0) begin
      n_fail++;
      $display("FAIL mid_merge_reset: got cnt=%h hc=%h m=%h, expected all 0", cnt6, hc6, m6);
    end
    @(negedge clk);
    reset = 1'b0;
    wait_code6(cyc, pulses);
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL mid_merge_no_code: got %0d pulses, expected 0", pulses);
    end
    play6();
    wait_code6(cyc, pulses);
    n_checks++;
    if (hc6 !== T1_HC || m6 !== T1_M || cyc !== 7) begin
      n_fail++;
      $display("FAIL mid_merge_rerun: got hc=%h m=%h at %0d, expected hc=%h m=%h at 7", hc6, m6, cyc, T1_HC, T1_M);
    end
  endtask

  task automatic test_merge_pulses();
    int cyc = -1;
    int pulses = 0;
    fill_test1();
    play6();
    @(negedge clk);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      gv6 = (i == 1 || i == 3);
      gd6 = (i == 1) ? 8'd1 : 8'd5;
      if (codev6) begin
        if (cyc < 0) cyc = i;
        pulses++;
      end
    end
    gv6 = 1'b0;
    n_checks++;
    if (pulses !== 1 || cyc !== 6) begin
      n_fail++;
      $display("FAIL merge_pulses_code: got %0d pulses at %0d, expected 1 at 6", pulses, cyc);
    end
    n_checks++;
    if (cnt6 !== T1_CNT || hc6 !== T1_HC || m6 !== T1_M) begin
      n_fail++;
      $display("FAIL merge_pulses_data: got cnt=%h hc=%h m=%h, expected test-1 values", cnt6, hc6, m6);
    end
  endtask

  task automatic test_back_to_back();
    int seen = 0;
    int cv_seen = 0;
    fill_test1();
    play6();
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (codev6) seen = 1;
    end
    n_checks++;
    if (seen !== 1) begin
      n_fail++;
      $display("FAIL b2b_done: got no code_valid, expected one");
    end
    gv6 = 1'b1;
    gd6 = 8'd1;
    @(negedge clk);
    gv6 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cv6) cv_seen++;
    end
    n_checks++;
    if (cv_seen !== 0 || cnt6 !== T1_CNT || hc6 !== T1_HC) begin
      n_fail++;
      $display("FAIL b2b_ignored: got %0d CNT_valid, cnt=%h hc=%h, expected 0 and test-1 values", cv_seen, cnt6, hc6);
    end
  endtask

  initial begin
    test_reset();
    test_main();
    test_small();
    test_ignore();
    test_count_width();
    test_reset_mid_merge();
    test_merge_pulses();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
